cdc_handshake_rx: RTL and testbench

- Receive end of a 4-phase req/ack clock-domain-crossing handshake. Lives entirely in the destination clock domain.
- The foreign-domain sender holds data_in stable while req_in is high. This block synchronizes req_in, captures data_in, presents the word to a local consumer over valid/ready, then returns ack_out.
- Pairs with the sender-side block that drives req_in/data_in from the source clock.

---
 rtl/cdc_hs_pkg.sv | 19 +
 rtl/cdc_handshake_rx_sync_bit.sv | 28 ++
 rtl/cdc_handshake_rx.sv | 123 ++++++++++++
 tb/tb_cdc_handshake_rx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// cdc_hs_pkg : shared types and defaults for the req/ack CDC handshake
// Rev 1.0
// ------------------------------------------------------------------
package cdc_hs_pkg;

  localparam int DATA_W_DFLT      = 8;
  localparam int SYNC_STAGES_DFLT = 2;
  localparam int CNT_W_DFLT       = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_POP = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cdc_handshake_rx_sync_bit.sv
`default_nettype none
// ------------------------------------------------------------------
// sync_bit : STAGES-flop single-bit synchronizer, async reset to 0
// Rev 1.0
// ------------------------------------------------------------------
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cdc_handshake_rx.sv
`default_nettype none
// ------------------------------------------------------------------
// cdc_handshake_rx : receive side of a 4-phase req/ack CDC handshake
// Rev 1.0
// ------------------------------------------------------------------
module cdc_handshake_rx
  import cdc_hs_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DFLT,
  parameter int SYNC_STAGES = SYNC_STAGES_DFLT,
  parameter int CNT_W       = CNT_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              err_early_drop,
  output logic [CNT_W-1:0]  xfer_count
);

  logic              w_req_sync;
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_req_prev;
  logic              r_valid;
  logic              r_ack;
  logic              r_err;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_valid_nxt;
  logic              w_ack_nxt;
  logic              w_err_nxt;
  logic              w_cap;
  logic              w_cnt_inc;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req_in),
    .q   (w_req_sync)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_ack_nxt   = r_ack;
    w_err_nxt   = 1'b0;
    w_cap       = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ack_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        if (w_req_sync) begin
          w_cap       = 1'b1;
          w_valid_nxt = 1'b1;
          w_state_nxt = WAIT_POP;
        end
      end
      WAIT_POP: begin
        // Pulse only on the falling edge of req_sync so a long stall gives one error.
        w_err_nxt = r_req_prev & ~w_req_sync;
        if (out_ready && r_valid) begin
          w_valid_nxt = 1'b0;
          w_ack_nxt   = 1'b1;
          w_state_nxt = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!w_req_sync) begin
          w_ack_nxt   = 1'b0;
          w_cnt_inc   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_ack_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_req_prev <= 1'b0;
      r_valid    <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_data     <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_prev <= w_req_sync;
      r_valid    <= w_valid_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      if (w_cap) begin
        r_data <= data_in;
      end
      if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign ack_out        = r_ack;
  assign out_valid      = r_valid;
  assign out_data       = r_data;
  assign err_early_drop = r_err;
  assign xfer_count     = r_cnt;
  assign busy           = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_rx.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_cdc_handshake_rx : self-checking bench for cdc_handshake_rx
// Rev 1.0
// ------------------------------------------------------------------
module tb_cdc_handshake_rx;

  localparam int DATA_W = 8;
  localparam int SYNC   = 2;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_in;
  logic [DATA_W-1:0] data_in;
  logic              ack_out;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              busy;
  logic              err_early_drop;
  logic [CNT_W-1:0]  xfer_count;

  int checks   = 0;
  int errors   = 0;
  int err_seen = 0;

  typedef struct {
    logic [DATA_W-1:0] d;
    int                stall;
    bit                drop;
    logic [DATA_W-1:0] exp_d;
    int                exp_err;
  } vec_t;

  vec_t vt[17];

  cdc_handshake_rx #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_in         (req_in),
    .data_in        (data_in),
    .ack_out        (ack_out),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .busy           (busy),
    .err_early_drop (err_early_drop),
    .xfer_count     (xfer_count)
  );

  always #5 clk = ~clk;

  // A one-cycle pulse is seen exactly once at the falling edge.
  always @(negedge clk) begin
    if (err_early_drop === 1'b1) err_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_in    = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  // Plays both the source sender and the local consumer for one transfer.
  task automatic do_xfer(input logic [DATA_W-1:0] d, input int stall, input bit drop,
                         output logic [DATA_W-1:0] got, output int lat, output bit ok);
    int n;
    ok        = 1'b1;
    got       = '0;
    req_in    = 1'b1;
    data_in   = d;
    out_ready = 1'b0;
    n         = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    lat = n;
    if (!out_valid) begin
      ok = 1'b0;
    end else begin
      got     = out_data;
      data_in = ~d;
      if (drop) req_in = 1'b0;
      for (int i = 0; i < stall; i++) begin
        tick();
        if (!out_valid || out_data !== d || ack_out) ok = 1'b0;
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (!ack_out || out_valid) ok = 1'b0;
    end
    req_in = 1'b0;
    n = 0;
    while (ack_out && n < 20) begin
      tick();
      n++;
    end
    if (ack_out) ok = 1'b0;
    repeat (2) begin
      tick();
      if (out_valid || busy) ok = 1'b0;
    end
  endtask

  initial begin
    logic [DATA_W-1:0] got;
    int                lat;
    bit                ok;
    int                base;
    int                exp_cnt;
    int                exp_err;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] d;
    int                stall;
    bit                drop;
    logic              e;

    for (int i = 0; i < 17; i++) begin
      vt[i].d       = DATA_W'(i);
      vt[i].stall   = i % 4;
      vt[i].drop    = (i % 5 == 3);
      vt[i].exp_d   = DATA_W'(i);
      vt[i].exp_err = (vt[i].drop && vt[i].stall >= SYNC) ? 1 : 0;
    end

    // Reset state
    do_reset();
    check("rst_ack",   32'(ack_out),        32'd0);
    check("rst_valid", 32'(out_valid),      32'd0);
    check("rst_data",  32'(out_data),       32'd0);
    check("rst_busy",  32'(busy),           32'd0);
    check("rst_err",   32'(err_early_drop), 32'd0);
    check("rst_cnt",   32'(xfer_count),     32'd0);

    // Single transfer, consumer always ready
    req_in = 1'b1; data_in = 8'hA5; out_ready = 1'b1;
    tick(); check("lat_e1_valid", 32'(out_valid), 32'd0);
    tick(); check("lat_e2_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_e3_valid", 32'(out_valid), 32'd1);
    check("lat_e3_data",  32'(out_data),  32'hA5);
    check("lat_e3_ack",   32'(ack_out),   32'd0);
    check("lat_e3_busy",  32'(busy),      32'd1);
    tick();
    check("lat_e4_ack",   32'(ack_out),   32'd1);
    check("lat_e4_valid", 32'(out_valid), 32'd0);
    req_in = 1'b0;
    tick(); tick(); check("rel_f2_ack", 32'(ack_out), 32'd1);
    tick();
    check("rel_f3_ack",  32'(ack_out),    32'd0);
    check("rel_f3_cnt",  32'(xfer_count), 32'd1);
    check("rel_f3_busy", 32'(busy),       32'd0);

    // Consumer stall with data_in changing underneath
    out_ready = 1'b0; req_in = 1'b1; data_in = 8'h3C;
    repeat (3) tick();
    check("stall_valid", 32'(out_valid), 32'd1);
    data_in = 8'hC3;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_hold", 32'({ack_out, out_valid, out_data}), 32'({1'b0, 1'b1, 8'h3C}));
    end
    out_ready = 1'b1;
    tick();
    check("stall_pop_ack",   32'(ack_out),   32'd1);
    check("stall_pop_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0; req_in = 1'b0;
    repeat (3) tick();
    check("stall_rel_ack", 32'(ack_out),    32'd0);
    check("stall_rel_cnt", 32'(xfer_count), 32'd2);

    // Early drop; also confirms the changed data_in is captured next
    req_in = 1'b1;
    repeat (3) tick();
    check("new_capture", 32'(out_data), 32'hC3);
    req_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      e = (i == 2);
      check("drop_err", 32'(err_early_drop), 32'(e));
    end
    check("drop_still_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    check("drop_pop_ack", 32'(ack_out), 32'd1);
    out_ready = 1'b0;
    tick();
    check("drop_rel_ack",  32'(ack_out),    32'd0);
    check("drop_rel_busy", 32'(busy),       32'd0);
    check("drop_rel_cnt",  32'(xfer_count), 32'd3);

    // Async reset while in WAIT_REL, request still held high
    req_in = 1'b1; data_in = 8'h99; out_ready = 1'b1;
    repeat (4) tick();
    check("arst_pre_ack", 32'(ack_out), 32'd1);
    out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_ack",  32'(ack_out),    32'd0);
    check("arst_busy", 32'(busy),       32'd0);
    check("arst_cnt",  32'(xfer_count), 32'd0);
    data_in = 8'h42;
    #1 rst = 1'b0;
    tick(); check("arst_e1_valid", 32'(out_valid), 32'd0);
    tick(); check("arst_e2_valid", 32'(out_valid), 32'd0);
    tick();
    check("arst_e3_valid", 32'(out_valid), 32'd1);
    check("arst_e3_data",  32'(out_data),  32'h42);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; req_in = 1'b0;
    repeat (3) tick();
    check("arst_done_cnt", 32'(xfer_count), 32'd1);

    // Table: 17 transfers 0..16 across the 4-bit counter wrap
    do_reset();
    for (int i = 0; i < 17; i++) begin
      base = err_seen;
      do_xfer(vt[i].d, vt[i].stall, vt[i].drop, got, lat, ok);
      check("tbl_data", 32'(got), 32'(vt[i].exp_d));
      check("tbl_lat",  32'(lat), 32'(SYNC + 1));
      check("tbl_hs",   32'(ok),  32'd1);
      check("tbl_err",  32'(err_seen - base), 32'(vt[i].exp_err));
    end
    check("tbl_wrap_cnt", 32'(xfer_count), 32'd1);

    // Randomized transfers against a queue/arithmetic reference
    do_reset();
    exp_cnt = 0;
    exp_err = 0;
    base    = err_seen;
    for (int i = 0; i < 30; i++) begin
      d     = DATA_W'($urandom);
      stall = int'($urandom_range(0, 5));
      drop  = ($urandom_range(0, 3) == 0);
      exp_q.push_back(d);
      if (drop && stall >= SYNC) exp_err++;
      do_xfer(d, stall, drop, got, lat, ok);
      check("rnd_data", 32'(got), 32'(exp_q.pop_front()));
      check("rnd_hs",   32'(ok),  32'd1);
      exp_cnt++;
    end
    check("rnd_cnt", 32'(xfer_count), 32'(exp_cnt % (1 << CNT_W)));
    check("rnd_err", 32'(err_seen - base), 32'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
